// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: AXI4-Stream word output of the configurable UART receiver.
//   tdata  : received word, LSB = first bit on the line, right-aligned
//   tvalid : word available
//   tready : consumer accept
//   tuser  : parity error flag belonging to the held word
// master = receiver side, slave = consumer side.
interface uart_rx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tuser, output tready);
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with AXI4-Stream output.
// Synchronises rxd, votes 3 samples around each bit centre, supports 5..DATA_WIDTH
// data bits, none/even/odd/mark/space parity, 1 or 2 stop bits, break detection.
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   rxd            : asynchronous serial input, idle high
//   m_axis         : stream output (tdata/tvalid/tready/tuser)
//   prescale       : bit period = prescale*8 clocks, 0 keeps the receiver idle
//   data_bits      : word length (clamped to 5..DATA_WIDTH)
//   parity_mode    : 0 none, 1 even, 2 odd, 3 mark, 4 space, 5..7 none
//   stop_bits      : 0 one stop bit, 1 two stop bits
//   busy           : start detection until return to IDLE
//   overrun_error, frame_error, parity_error, break_detect : 1-cycle pulses
//
// state     | meaning
// IDLE      | waiting for rxd_s low with prescale != 0
// START     | checking the start bit at its centre (false start -> IDLE)
// DATA      | one vote per data bit, shifted in LSB-first
// PARITY    | voting the parity bit
// STOP      | voting one or two stop bits, completing or flagging the frame
// WAIT_IDLE | after a frame/break error, hold busy until the line is high
module uart_rx_cfg #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  uart_rx_cfg_if.master        m_axis,
  input  logic [15:0]          prescale,
  input  logic [3:0]           data_bits,
  input  logic [2:0]           parity_mode,
  input  logic                 stop_bits,
  output logic                 busy,
  output logic                 overrun_error,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 break_detect
);
  // prescale*8 needs 19 bits so the bit counter never wraps early
  localparam int CW = 19;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          ctr_q, ctr_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic [DATA_WIDTH-1:0]  sr_q, sr_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d, nbits_q, nbits_d;
  logic [2:0]             pmode_q, pmode_d;
  logic                   two_stop_q, two_stop_d, stop_idx_q, stop_idx_d;
  logic                   par_acc_q, par_acc_d, all_zero_q, all_zero_d, perr_q, perr_d;
  logic [15:0]            prescale_q, prescale_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d, tuser_q, tuser_d, busy_q, busy_d;
  logic                   ovr_q, ovr_d, ferr_q, ferr_d, perr_p_q, perr_p_d, brk_q, brk_d;

  logic          rxd_s, vote_now, vote, complete, exp_par;
  logic [CW-1:0] t_m1, h_c;

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign t_m1  = {prescale_q, 3'b000} - CW'(1);
  assign h_c   = {1'b0, prescale_q, 2'b00};
  assign vote_now = (ctr_q == h_c + CW'(1));
  assign vote  = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], rxd};
    ctr_d      = (ctr_q == t_m1) ? '0 : ctr_q + CW'(1);
    s0_d       = (ctr_q == h_c - CW'(1)) ? rxd_s : s0_q;
    s1_d       = (ctr_q == h_c) ? rxd_s : s1_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    pmode_d    = pmode_q;
    two_stop_d = two_stop_q;
    stop_idx_d = stop_idx_q;
    par_acc_d  = par_acc_q;
    all_zero_d = all_zero_q;
    perr_d     = perr_q;
    prescale_d = prescale_q;
    tdata_d    = tdata_q;
    tuser_d    = tuser_q;
    tvalid_d   = tvalid_q & ~m_axis.tready;
    ovr_d      = 1'b0;
    ferr_d     = 1'b0;
    perr_p_d   = 1'b0;
    brk_d      = 1'b0;
    complete   = 1'b0;

    case (pmode_q)
      3'd1:    exp_par = par_acc_q;
      3'd2:    exp_par = ~par_acc_q;
      3'd3:    exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        ctr_d = '0;
        if (!rxd_s && prescale != 16'd0) begin
          prescale_d = prescale;
          if (data_bits < 4'd5)                    nbits_d = 4'd5;
          else if (data_bits > 4'(DATA_WIDTH))     nbits_d = 4'(DATA_WIDTH);
          else                                     nbits_d = data_bits;
          pmode_d    = (parity_mode > 3'd4) ? 3'd0 : parity_mode;
          two_stop_d = stop_bits;
          sr_d       = '0;
          bit_cnt_d  = 4'd0;
          par_acc_d  = 1'b0;
          all_zero_d = 1'b1;
          perr_d     = 1'b0;
          stop_idx_d = 1'b0;
          state_d    = S_START;
        end
      end
      // ctr keeps free-running across bits so every later vote lands one T apart
      S_START: begin
        if (vote_now) state_d = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (vote_now) begin
          sr_d       = sr_q | (DATA_WIDTH'(vote) << bit_cnt_q);
          par_acc_d  = par_acc_q ^ vote;
          all_zero_d = all_zero_q & ~vote;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == nbits_q - 4'd1) state_d = (pmode_q != 3'd0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (vote_now) begin
          perr_d     = (vote != exp_par);
          all_zero_d = all_zero_q & ~vote;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (vote_now) begin
          if (!vote) begin
            if (all_zero_q) brk_d  = 1'b1;
            else            ferr_d = 1'b1;
            state_d = S_WAIT_IDLE;
          end else if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // a slot is free if empty or being drained this very cycle
    if (complete) begin
      if (!tvalid_q || m_axis.tready) begin
        tdata_d  = sr_q;
        tuser_d  = perr_q;
        tvalid_d = 1'b1;
        perr_p_d = perr_q;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync_q     <= '1;
      ctr_q      <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      sr_q       <= '0;
      bit_cnt_q  <= 4'd0;
      nbits_q    <= 4'd5;
      pmode_q    <= 3'd0;
      two_stop_q <= 1'b0;
      stop_idx_q <= 1'b0;
      par_acc_q  <= 1'b0;
      all_zero_q <= 1'b0;
      perr_q     <= 1'b0;
      prescale_q <= 16'd0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tuser_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_p_q   <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      ctr_q      <= ctr_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      pmode_q    <= pmode_d;
      two_stop_q <= two_stop_d;
      stop_idx_q <= stop_idx_d;
      par_acc_q  <= par_acc_d;
      all_zero_q <= all_zero_d;
      perr_q     <= perr_d;
      prescale_q <= prescale_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tuser_q    <= tuser_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      perr_p_q   <= perr_p_d;
      brk_q      <= brk_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tuser  = tuser_q;
  assign busy          = busy_q;
  assign overrun_error = ovr_q;
  assign frame_error   = ferr_q;
  assign parity_error  = perr_p_q;
  assign break_detect  = brk_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: a table of frames plus hand-written sequences
// for false start, frame error, break, overrun and reset mid-frame.
module tb_uart_rx_cfg;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] prescale = 16'd2;
  logic [3:0]  data_bits = 4'd8;
  logic [2:0]  parity_mode = 3'd0;
  logic        stop_bits = 1'b0;
  logic        busy, overrun_error, frame_error, parity_error, break_detect;

  uart_rx_cfg_if #(.DATA_WIDTH(DW)) axis ();

  uart_rx_cfg #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .m_axis(axis),
    .prescale(prescale), .data_bits(data_bits), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .busy(busy), .overrun_error(overrun_error),
    .frame_error(frame_error), .parity_error(parity_error), .break_detect(break_detect)
  );

  always #5 clk = ~clk;

  // monitor: pulse counters and a log of accepted words {tuser, tdata}
  int n_ovr = 0, n_ferr = 0, n_perr = 0, n_brk = 0, n_vcyc = 0, n_words = 0;
  logic [DW:0] word_log [256];
  always @(negedge clk) begin
    if (overrun_error) n_ovr++;
    if (frame_error)   n_ferr++;
    if (parity_error)  n_perr++;
    if (break_detect)  n_brk++;
    if (axis.tvalid)   n_vcyc++;
    if (axis.tvalid && axis.tready) begin
      word_log[n_words % 256] = {axis.tuser, axis.tdata};
      n_words++;
    end
  end

  int n_cmp = 0, n_err = 0;
  int tT = 16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b, input int glitch_at);
    for (int c = 0; c < tT; c++) begin
      rxd = (c == glitch_at) ? ~b : b;
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                            input bit pbit, input int nstop, input int glitch_bit,
                            input bit stop_val);
    send_bit(1'b0, -1);
    for (int i = 0; i < nbits; i++) send_bit(data[i], (i == glitch_bit) ? 8 : -1);
    if (has_par) send_bit(pbit, -1);
    for (int s = 0; s < nstop; s++) send_bit(stop_val, -1);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [3:0] cfg_bits;
    logic [2:0] cfg_pmode;
    logic       cfg_stop;
    int         send_bits;
    bit         has_par;
    bit         pbit;
    int         nstop;
    int         glitch_bit;
    logic [7:0] data;
    logic [7:0] exp_data;
    bit         exp_user;
  } vec_t;

  vec_t vecs [8];

  int w0, o0, f0, p0, b0, v0;

  task automatic snap();
    w0 = n_words; o0 = n_ovr; f0 = n_ferr; p0 = n_perr; b0 = n_brk; v0 = n_vcyc;
  endtask

  initial begin
    // cfg_bits cfg_pmode cfg_stop send_bits has_par pbit nstop glitch data exp_data exp_user
    vecs[0] = '{4'd8,  3'd0, 1'b0, 8, 1'b0, 1'b0, 1, -1, 8'hA5, 8'hA5, 1'b0}; // 8N1
    vecs[1] = '{4'd7,  3'd1, 1'b1, 7, 1'b1, 1'b0, 2, -1, 8'h41, 8'h41, 1'b0}; // 7E2 good
    vecs[2] = '{4'd7,  3'd1, 1'b1, 7, 1'b1, 1'b1, 2, -1, 8'h41, 8'h41, 1'b1}; // 7E2 flipped
    vecs[3] = '{4'd8,  3'd0, 1'b0, 8, 1'b0, 1'b0, 1,  2, 8'h5A, 8'h5A, 1'b0}; // mid-bit glitch
    vecs[4] = '{4'd5,  3'd2, 1'b0, 5, 1'b1, 1'b0, 1, -1, 8'h15, 8'h15, 1'b0}; // 5O1
    vecs[5] = '{4'd3,  3'd3, 1'b0, 5, 1'b1, 1'b1, 1, -1, 8'h0B, 8'h0B, 1'b0}; // clamp to 5, mark
    vecs[6] = '{4'd15, 3'd4, 1'b0, 8, 1'b1, 1'b0, 1, -1, 8'hFF, 8'hFF, 1'b0}; // clamp to 8, space
    vecs[7] = '{4'd8,  3'd6, 1'b1, 8, 1'b0, 1'b0, 2, -1, 8'h80, 8'h80, 1'b0}; // mode 6 = none, 2 stop

    axis.tready = 1'b1;
    idle(3);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tdata", axis.tdata, 0);
    chk("rst_tuser", axis.tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {overrun_error, frame_error, parity_error, break_detect}, 0);
    rst_n = 1'b1;
    idle(5);

    for (int v = 0; v < 8; v++) begin
      data_bits = vecs[v].cfg_bits;
      parity_mode = vecs[v].cfg_pmode;
      stop_bits = vecs[v].cfg_stop;
      snap();
      send_frame(vecs[v].data, vecs[v].send_bits, vecs[v].has_par, vecs[v].pbit,
                 vecs[v].nstop, vecs[v].glitch_bit, 1'b1);
      idle(2 * tT);
      chk($sformatf("v%0d_words", v), n_words - w0, 1);
      chk($sformatf("v%0d_tdata", v), word_log[w0 % 256][7:0], vecs[v].exp_data);
      chk($sformatf("v%0d_tuser", v), word_log[w0 % 256][8], vecs[v].exp_user);
      chk($sformatf("v%0d_perr_pulse", v), n_perr - p0, vecs[v].exp_user);
      chk($sformatf("v%0d_other_pulses", v), (n_ovr - o0) + (n_ferr - f0) + (n_brk - b0), 0);
      chk($sformatf("v%0d_tvalid_cycles", v), n_vcyc - v0, 1);
      chk($sformatf("v%0d_busy", v), busy, 0);
    end

    // false start: 4-clock low glitch
    data_bits = 4'd8; parity_mode = 3'd0; stop_bits = 1'b0;
    snap();
    rxd = 1'b0; idle(4); rxd = 1'b1;
    idle(3 * tT);
    chk("glitch_words", n_words - w0, 0);
    chk("glitch_pulses", (n_ovr - o0) + (n_ferr - f0) + (n_brk - b0) + (n_perr - p0), 0);
    chk("glitch_busy", busy, 0);

    // frame error: 0x55 with stop bit 0, line then held low
    snap();
    send_frame(8'h55, 8, 1'b0, 1'b0, 1, -1, 1'b0);
    rxd = 1'b0;
    idle(2 * tT);
    chk("ferr_pulse", n_ferr - f0, 1);
    chk("ferr_brk", n_brk - b0, 0);
    chk("ferr_words", n_words - w0, 0);
    chk("ferr_busy_held", busy, 1);
    rxd = 1'b1;
    idle(6);
    chk("ferr_busy_release", busy, 0);

    // break: line low for 12 bit times
    snap();
    rxd = 1'b0;
    idle(12 * tT);
    chk("brk_pulse", n_brk - b0, 1);
    chk("brk_ferr", n_ferr - f0, 0);
    chk("brk_words", n_words - w0, 0);
    chk("brk_busy_held", busy, 1);
    rxd = 1'b1;
    idle(2 * tT);
    chk("brk_busy_release", busy, 0);

    // 0x3C after break; config changed mid-frame must not take effect
    snap();
    send_bit(1'b0, -1);
    data_bits = 4'd5; parity_mode = 3'd1; stop_bits = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(((8'h3C >> i) & 8'h01) != 8'h00, -1);
    send_bit(1'b1, -1);
    idle(2 * tT);
    chk("post_brk_words", n_words - w0, 1);
    chk("post_brk_tdata", word_log[w0 % 256], {1'b0, 8'h3C});
    chk("post_brk_pulses", (n_ovr - o0) + (n_ferr - f0) + (n_brk - b0) + (n_perr - p0), 0);
    data_bits = 4'd8; parity_mode = 3'd0; stop_bits = 1'b0;

    // overrun with tready low
    axis.tready = 1'b0;
    snap();
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, -1, 1'b1);
    idle(2 * tT);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, -1, 1'b1);
    idle(2 * tT);
    chk("ovr_tvalid", axis.tvalid, 1);
    chk("ovr_tdata", axis.tdata, 8'h11);
    chk("ovr_tuser", axis.tuser, 0);
    chk("ovr_pulse", n_ovr - o0, 1);
    chk("ovr_perr", n_perr - p0, 0);
    axis.tready = 1'b1;
    tick();
    chk("ovr_drain_words", n_words - w0, 1);
    chk("ovr_drain_data", word_log[w0 % 256], {1'b0, 8'h11});
    chk("ovr_drain_tvalid", axis.tvalid, 0);

    // reset mid-frame
    rxd = 1'b0;
    idle(tT + 20);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_tdata", axis.tdata, 0);
    chk("mrst_tvalid", axis.tvalid, 0);
    chk("mrst_busy", busy, 0);
    rxd = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(4);
    snap();
    send_frame(8'h96, 8, 1'b0, 1'b0, 1, -1, 1'b1);
    idle(2 * tT);
    chk("mrst_next_words", n_words - w0, 1);
    chk("mrst_next_data", word_log[w0 % 256], {1'b0, 8'h96});
    chk("mrst_next_pulses", (n_ovr - o0) + (n_ferr - f0) + (n_brk - b0) + (n_perr - p0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
